// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and default widths for the pipeline stage register
package pipe_pkg;

  localparam int DATA_W_DEF = 160;
  localparam int CTRL_W_DEF = 16;
  localparam int SR_N_DEF   = 3;
  localparam int SR_W_DEF   = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/dffe_w.sv
// rtl/dffe_w.sv - parametrised-width register with synchronous reset and load enable
module dffe_w #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_reg_p.sv
// rtl/pipe_stage_reg_p.sv - valid/ready pipeline stage register with flush and side registers
// PIPE_SKID_EN selects a 2-entry skid buffer with registered in_ready; default is single-entry.
module pipe_stage_reg_p
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SR_N   = SR_N_DEF,
  parameter int SR_W   = SR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  input  logic [SR_N-1:0]        sr_we,
  input  logic [SR_N*SR_W-1:0]   sr_din,
  output logic [SR_N*SR_W-1:0]   sr_q
);

  logic              xfer_in;
  logic              xfer_out;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign xfer_in  = in_valid & in_ready & ~flush;
  assign xfer_out = out_valid & out_ready;
  assign out_ctrl = ctrl_q;
  assign out_data = data_q;

`ifdef PIPE_SKID_EN
  skid_state_e       state_q, state_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q;

  // in_ready_q tracks "skid not full" so out_ready never reaches in_ready
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = ~rst_n & (in_ready_q | flush);

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = EMPTY;
      ctrl_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            state_d = FULL;
            ctrl_d  = in_ctrl;
            data_d  = in_data;
          end
        end
        FULL: begin
          if (xfer_in && xfer_out) begin
            ctrl_d = in_ctrl;
            data_d = in_data;
          end else if (xfer_in) begin
            state_d     = SKID;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (xfer_out) begin
            state_d = EMPTY;
            ctrl_d  = '0;
          end
        end
        SKID: begin
          if (xfer_out) begin
            state_d = FULL;
            ctrl_d  = skid_ctrl_q;
            data_d  = skid_data_q;
          end
        end
        default: begin
          state_d = EMPTY;
          ctrl_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= EMPTY;
      ctrl_q      <= '0;
      data_q      <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= (state_d != SKID);
    end
  end
`else
  logic valid_q, valid_d;

  assign out_valid = valid_q;
  assign in_ready  = ~rst_n & (flush | ~valid_q | out_ready);

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (xfer_in) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      data_d  = in_data;
    end else if (xfer_out) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end
`endif

  // side registers load whenever enabled, regardless of stall or flush
  for (genvar i = 0; i < SR_N; i++) begin : g_sr
    dffe_w #(
      .W(SR_W)
    ) u_sr (
      .clk_i (clk),
      .rst_i (rst_n),
      .en_i  (sr_we[i]),
      .d_i   (sr_din[i*SR_W +: SR_W]),
      .q_o   (sr_q[i*SR_W +: SR_W])
    );
  end

endmodule

// File: tb/tb_pipe_stage_reg_p.sv
// tb/tb_pipe_stage_reg_p.sv - self-checking bench for pipe_stage_reg_p against a queue model
module tb_pipe_stage_reg_p;

  localparam int DW = 160;
  localparam int CW = 16;
  localparam int SN = 3;
  localparam int SW = 32;
`ifdef PIPE_SKID_EN
  localparam bit SKID_MODE = 1'b1;
`else
  localparam bit SKID_MODE = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_ctrl;
  logic [DW-1:0]    in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_ctrl;
  logic [DW-1:0]    out_data;
  logic [SN-1:0]    sr_we;
  logic [SN*SW-1:0] sr_din;
  logic [SN*SW-1:0] sr_q;

  pipe_stage_reg_p #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .SR_N  (SN),
    .SR_W  (SW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .sr_we    (sr_we),
    .sr_din   (sr_din),
    .sr_q     (sr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  // Model: beats held by the stage in arrival order, plus what out_data shows when empty
  beat_t            held[$];
  logic [DW-1:0]    last_d;
  logic [SN*SW-1:0] sr_m;
  int               beats_out;
  int               errors;
  int               checks;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_rdy(input logic r, input logic fl, input logic ordy);
    if (r) return 1'b0;
    if (fl) return 1'b1;
    if (SKID_MODE) return held.size() < 2;
    return (held.size() == 0) || ordy;
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input logic ordy, input logic fl,
                       input logic [SN-1:0] we, input logic [SN*SW-1:0] din);
    bit    er;
    beat_t b;
    @(negedge clk);
    rst_n     = r;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    sr_we     = we;
    sr_din    = din;
    #1;
    er = exp_rdy(r, fl, ordy);
    chk("in_ready", {191'd0, in_ready}, {191'd0, er});
    chk("out_valid", {191'd0, out_valid}, {191'd0, held.size() > 0});
    chk("out_ctrl", {176'd0, out_ctrl}, {176'd0, (held.size() > 0) ? held[0].c : {CW{1'b0}}});
    chk("out_data", {32'd0, out_data}, {32'd0, (held.size() > 0) ? held[0].d : last_d});
    chk("sr_q", {96'd0, sr_q}, {96'd0, sr_m});
    if (r) begin
      held.delete();
      last_d = '0;
      sr_m   = '0;
    end else begin
      for (int i = 0; i < SN; i++) if (we[i]) sr_m[i*SW +: SW] = din[i*SW +: SW];
      if (fl) begin
        if (held.size() > 0) last_d = held[0].d;
        held.delete();
      end else begin
        if (held.size() > 0 && ordy) begin
          b = held.pop_front();
          last_d = b.d;
          beats_out++;
        end
        if (v && er) begin
          b.c = c;
          b.d = d;
          held.push_back(b);
        end
      end
    end
  endtask

  task automatic idle(input logic r, input logic ordy);
    cycle(r, 1'b0, '0, '0, ordy, 1'b0, '0, '0);
  endtask

  initial begin
    logic [CW-1:0]    rc;
    logic [DW-1:0]    rd;
    logic [SN*SW-1:0] rs;
    int               start_beats;
    int               n;
    errors    = 0;
    checks    = 0;
    beats_out = 0;
    last_d    = '0;
    sr_m      = '0;
    held.delete();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    sr_we     = '0;
    sr_din    = '0;
    @(posedge clk);

    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("rst_in_ready", {191'd0, in_ready}, 192'd0);

    // pass-through 1..5 with out_ready held high
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b1, CW'(i + 16), DW'(i), 1'b1, 1'b0, '0, '0);
      if (i == 1) chk("post_rst_ready", {191'd0, in_ready}, 192'd1);
      chk("pt_valid", {191'd0, out_valid}, {191'd0, i >= 2});
      chk("pt_data", {32'd0, out_data}, (i >= 2) ? 192'(i - 1) : 192'd0);
    end
    idle(1'b0, 1'b1);
    chk("pt_last", {32'd0, out_data}, 192'd5);
    idle(1'b0, 1'b1);
    chk("pt_drained_ctrl", {176'd0, out_ctrl}, 192'd0);
    chk("pt_hold_data", {32'd0, out_data}, 192'd5);

    // stall with 0xA held, 0xB offered
    cycle(1'b0, 1'b1, 16'h00AA, DW'('hA), 1'b1, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 16'h00BB, DW'('hB), 1'b0, 1'b0, '0, '0);
      chk("stall_data", {32'd0, out_data}, 192'hA);
      chk("stall_ready", {191'd0, in_ready}, {191'd0, SKID_MODE && (k == 0)});
    end
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    chk("drain_data", {32'd0, out_data}, SKID_MODE ? 192'hB : 192'hA);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    // flush while holding 0xA with 0xB arriving
    cycle(1'b0, 1'b1, 16'h00AA, DW'('hA), 1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 16'h00BB, DW'('hB), 1'b0, 1'b1, '0, '0);
    chk("flush_ready", {191'd0, in_ready}, 192'd1);
    idle(1'b0, 1'b1);
    chk("flush_valid", {191'd0, out_valid}, 192'd0);
    chk("flush_ctrl", {176'd0, out_ctrl}, 192'd0);
    idle(1'b0, 1'b1);

    // side registers written during a flush
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 3'b010, {32'h0, 32'h0000_0D1D, 32'h0});
    cycle(1'b0, 1'b1, 16'h1, DW'('h77), 1'b0, 1'b1, 3'b101,
          {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA});
    idle(1'b0, 1'b1);
    chk("sr_flush", {96'd0, sr_q}, {96'd0, 32'hCCCC_CCCC, 32'h0000_0D1D, 32'hAAAA_AAAA});

    // reset asserted with the stage (and skid, if present) full
    cycle(1'b0, 1'b1, 16'h11, DW'('h11), 1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 16'h22, DW'('h22), 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 16'h33, DW'('h33), 1'b0, 1'b0, '0, '0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("rst_mid_valid", {191'd0, out_valid}, 192'd0);
    chk("rst_mid_ready", {191'd0, in_ready}, 192'd0);
    idle(1'b0, 1'b0);
    chk("rst_rel_ready", {191'd0, in_ready}, 192'd1);
    idle(1'b0, 1'b0);
    chk("rst_rel_empty", {191'd0, out_valid}, 192'd0);

    // random valid/ready at 50%, rare flush and reset
    start_beats = beats_out;
    n = 0;
    while ((beats_out - start_beats) < 10000 && n < 60000) begin
      rc = CW'($urandom());
      rd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rs = {$urandom(), $urandom(), $urandom()};
      cycle(($urandom_range(0, 1999) == 0), 1'($urandom()), rc, rd, 1'($urandom()),
            ($urandom_range(0, 127) == 0), 3'($urandom()) & 3'($urandom()), rs);
      n++;
    end
    chk("beat_budget", {191'd0, (beats_out - start_beats) >= 10000}, 192'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
